ddr2_preload_wr: RTL and testbench

Write-side preload engine for the DDR2 frame store. After MIG initialisation it walks every display line and issues burst-write commands through the MIG user interface. Each line is filled with a known line-index pattern, so the display read path (rd_go / rd_xfr_en / line buffer) can fetch and self-check frames. It sits in ddr_mgr_main between the MIG user port and the control logic that launches display reads. It raises buffer_init_done when the whole frame has been written.

---
 rtl/ddr2_preload_wr.sv | 161 ++++++++++++++++
 tb/tb_ddr2_preload_wr.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_preload_wr.sv
// rtl/ddr2_preload_wr.sv - DDR2 frame-store preload writer; PRELOAD_ADDR_PATTERN_EN selects address-pattern data
module ddr2_preload_wr #(
  parameter int          LINES           = 600,
  parameter int          BURSTS_PER_LINE = 200,
  parameter int          BURST_WORDS     = 2,
  parameter logic [23:0] ADDR_STEP       = 24'h000004,
  parameter logic [23:0] LINE_STRIDE     = 24'h000400
) (
  input  logic        mem_clk0,
  input  logic        mem_rst_s_n,
  input  logic        mig_init_done,
  input  logic        wr_go,
  input  logic        mig_auto_ref_req,
  input  logic        mig_ar_done,
  input  logic        mig_user_cmd_ack,
  output logic [2:0]  mig_user_command_register,
  output logic [23:0] mig_user_input_addr,
  output logic [31:0] mig_user_input_data,
  output logic [3:0]  mig_user_data_mask,
  output logic        mig_burst_done,
  output logic        wr_busy,
  output logic        buffer_init_done
);

  localparam int BW = (BURSTS_PER_LINE > 1) ? $clog2(BURSTS_PER_LINE) : 1;
  localparam int WW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam logic [10:0]   LINE_LAST  = 11'(LINES - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURSTS_PER_LINE - 1);
  localparam logic [WW-1:0] WORD_LAST  = WW'(BURST_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REF_WAIT,
    ST_CMD,
    ST_DATA,
    ST_BDONE,
    ST_ACK_LOW,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [10:0]   line_q, line_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [WW-1:0] word_q, word_d;
  logic          bd_q, bd_d;
  logic          done_q, done_d;

  logic [23:0]   addr_w;
  logic [31:0]   data_w;

  // Burst address derives from the counters, so it only moves when they advance between bursts
  assign addr_w = (24'(line_q) * LINE_STRIDE) + (24'(burst_q) * ADDR_STEP);

`ifdef PRELOAD_ADDR_PATTERN_EN
  assign data_w = {8'h00, addr_w};
`else
  logic [15:0] beat_w;
  assign beat_w = {5'b00000, line_q};
  assign data_w = {beat_w, beat_w};
`endif

  // State and counter registers, cleared by synchronous reset
  always_ff @(posedge mem_clk0) begin
    if (!mem_rst_s_n) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      burst_q <= '0;
      word_q  <= '0;
      bd_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      burst_q <= burst_d;
      word_q  <= word_d;
      bd_q    <= bd_d;
      done_q  <= done_d;
    end
  end

  // Next-state: walk bursts within lines, pausing for refresh only between bursts
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    burst_d = burst_q;
    word_d  = word_q;
    bd_d    = bd_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (wr_go && mig_init_done) begin
          line_d  = '0;
          burst_d = '0;
          state_d = mig_auto_ref_req ? ST_REF_WAIT : ST_CMD;
        end
      end
      ST_REF_WAIT: begin
        if (mig_ar_done) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (mig_user_cmd_ack) begin
          word_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (mig_user_cmd_ack) begin
          if (word_q == WORD_LAST) begin
            bd_d    = 1'b0;
            state_d = ST_BDONE;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      ST_BDONE: begin
        if (!bd_q) bd_d = 1'b1;
        else       state_d = ST_ACK_LOW;
      end
      ST_ACK_LOW: begin
        if (!mig_user_cmd_ack) begin
          if (line_q == LINE_LAST && burst_q == BURST_LAST) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            if (burst_q == BURST_LAST) begin
              burst_d = '0;
              line_d  = line_q + 1'b1;
            end else begin
              burst_d = burst_q + 1'b1;
            end
            state_d = mig_auto_ref_req ? ST_REF_WAIT : ST_CMD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: write command holds through the first burst_done cycle only
  always_comb begin
    mig_user_command_register = 3'b000;
    mig_burst_done            = 1'b0;
    wr_busy                   = 1'b1;
    case (state_q)
      ST_CMD, ST_DATA: mig_user_command_register = 3'b100;
      ST_BDONE: begin
        mig_burst_done = 1'b1;
        if (!bd_q) mig_user_command_register = 3'b100;
      end
      ST_IDLE, ST_DONE: wr_busy = 1'b0;
      default: ;
    endcase
  end

  assign mig_user_input_addr = addr_w;
  assign mig_user_input_data = data_w;
  assign mig_user_data_mask  = 4'h0;
  assign buffer_init_done    = done_q;

endmodule

// File: tb/tb_ddr2_preload_wr.sv
// tb/tb_ddr2_preload_wr.sv - self-checking bench for ddr2_preload_wr with a behavioural MIG model
module tb_ddr2_preload_wr;

  localparam int          LINES  = 2;
  localparam int          BPL    = 2;
  localparam int          BWORDS = 2;
  localparam int          TOTAL  = LINES * BPL;
  localparam logic [23:0] STEP   = 24'h000004;
  localparam logic [23:0] STRIDE = 24'h000400;

  logic        clk = 1'b0;
  logic        rstn, init_done, wr_go, ref_req, ar_done, ack;
  logic [2:0]  cmd;
  logic [23:0] addr;
  logic [31:0] data;
  logic [3:0]  mask;
  logic        bdone, busy, done;

  always #5 clk = ~clk;

  ddr2_preload_wr #(
    .LINES(LINES), .BURSTS_PER_LINE(BPL), .BURST_WORDS(BWORDS),
    .ADDR_STEP(STEP), .LINE_STRIDE(STRIDE)
  ) dut (
    .mem_clk0(clk), .mem_rst_s_n(rstn), .mig_init_done(init_done), .wr_go(wr_go),
    .mig_auto_ref_req(ref_req), .mig_ar_done(ar_done), .mig_user_cmd_ack(ack),
    .mig_user_command_register(cmd), .mig_user_input_addr(addr),
    .mig_user_input_data(data), .mig_user_data_mask(mask),
    .mig_burst_done(bdone), .wr_busy(busy), .buffer_init_done(done)
  );

  int checks, errors;
  int bi, words, bd_cnt, lat, lat_cnt, gap_cnt, tail_cnt;
  bit in_burst, acked, gap_en, ref_hold, ever_done;

  function automatic logic [23:0] exp_addr(input int i);
    int ln, b;
    ln = i / BPL;
    b  = i % BPL;
    return 24'(ln * int'(STRIDE) + b * int'(STEP));
  endfunction

  function automatic logic [31:0] exp_data(input int i);
    logic [15:0] beat;
`ifdef PRELOAD_ADDR_PATTERN_EN
    beat = 16'h0;
    return {8'h00, exp_addr(i)} | {beat, beat};
`else
    beat = {5'b00000, 11'(i / BPL)};
    return {beat, beat};
`endif
  endfunction

  // MIG model and burst scoreboard, evaluated each falling edge
  task automatic monitor();
    logic [2:0] exp_cmd;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        in_burst = 0; acked = 0; words = 0; bd_cnt = 0; ack = 1'b0;
        gap_cnt = 0; tail_cnt = 0; lat_cnt = 0; bi = 0;
      end else begin
        if (wr_go && init_done && !busy) bi = 0;
        if (cmd == 3'b100 && !bdone) begin
          if (!in_burst) begin
            in_burst = 1; acked = 0; words = 0; gap_cnt = 0; lat_cnt = 0;
            lat = int'($urandom_range(1, 4));
            tail_cnt = int'($urandom_range(0, 2));
            checks++;
            if (bi >= TOTAL || ref_hold) begin
              errors++;
              $display("FAIL burst_start: burst %0d began with ref_hold=%0d, required no command", bi, ref_hold);
            end
            checks++;
            if (done !== ever_done) begin
              errors++;
              $display("FAIL done_flag: got %0b, expected %0b at burst %0d", done, ever_done, bi);
            end
          end
          checks++;
          if (addr !== exp_addr(bi)) begin
            errors++;
            $display("FAIL addr: got %h, expected %h (burst %0d)", addr, exp_addr(bi), bi);
          end
          checks++;
          if (data !== exp_data(bi)) begin
            errors++;
            $display("FAIL data: got %h, expected %h (burst %0d)", data, exp_data(bi), bi);
          end
          checks++;
          if (mask !== 4'h0) begin
            errors++;
            $display("FAIL mask: got %h, expected 0", mask);
          end
        end else if (bdone) begin
          bd_cnt++;
          exp_cmd = (bd_cnt == 1) ? 3'b100 : 3'b000;
          checks++;
          if (cmd !== exp_cmd) begin
            errors++;
            $display("FAIL bdone_cmd: got %b, expected %b in burst_done cycle %0d", cmd, exp_cmd, bd_cnt);
          end
        end else if (bd_cnt > 0) begin
          checks++;
          if (bd_cnt !== 2) begin
            errors++;
            $display("FAIL bdone_len: got %0d cycles, expected 2", bd_cnt);
          end
          checks++;
          if (words !== BWORDS) begin
            errors++;
            $display("FAIL words: got %0d, expected %0d (burst %0d)", words, BWORDS, bi);
          end
          bi++; in_burst = 0; bd_cnt = 0;
        end else if (in_burst) begin
          errors++;
          $display("FAIL cmd_drop: command left write without burst_done, burst %0d", bi);
          in_burst = 0;
        end
        // ack value the DUT samples on the coming rising edge
        if (cmd == 3'b100 && !bdone) begin
          if (!acked) begin
            if (lat_cnt >= lat - 1) ack = 1'b1;
            else begin ack = 1'b0; lat_cnt++; end
          end else if (gap_en && words == 1 && gap_cnt < 2) begin
            ack = 1'b0; gap_cnt++;
          end else begin
            ack = 1'b1;
          end
        end else if (!bdone) begin
          if (ack && tail_cnt > 0) tail_cnt--;
          else ack = 1'b0;
        end
        if (cmd == 3'b100 && !bdone && ack) begin
          if (!acked) acked = 1;
          else words++;
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++; if (cmd !== 3'b000) begin errors++; $display("FAIL %s_cmd: got %b, expected 000", tag, cmd); end
    checks++; if (addr !== 24'h0) begin errors++; $display("FAIL %s_addr: got %h, expected 0", tag, addr); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL %s_data: got %h, expected 0", tag, data); end
    checks++; if (mask !== 4'h0) begin errors++; $display("FAIL %s_mask: got %h, expected 0", tag, mask); end
    checks++; if (bdone !== 1'b0) begin errors++; $display("FAIL %s_bdone: got %b, expected 0", tag, bdone); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b, expected 0", tag, busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done: got %b, expected 0", tag, done); end
  endtask

  task automatic start_frame();
    @(posedge clk); #1 wr_go = 1'b1;
    @(posedge clk); #1 wr_go = 1'b0;
    checks++;
    if (cmd !== 3'b100) begin errors++; $display("FAIL start_cmd: got %b, expected 100", cmd); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b, expected 1", busy); end
  endtask

  // inject: 0 none, 1 random refreshes, 2 refresh during data of burst 0
  task automatic wait_frame(input int inject, input bit go_mid);
    int hold_cnt = 0;
    int nref = 0;
    bit go_done = 0;
    bit seen = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      if (wr_go) wr_go = 1'b0;
      if (ar_done) begin ar_done = 1'b0; ref_req = 1'b0; end
      if (!busy) begin seen = 1; break; end
      if (go_mid && !go_done && bi == 1) begin wr_go = 1'b1; go_done = 1; end
      if (ref_hold) begin
        if (!in_burst && ack == 1'b0 && cmd == 3'b000 && !bdone) begin
          if (hold_cnt > 0) hold_cnt--;
          else begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL ref_park: busy %b, expected 1", busy); end
            ar_done = 1'b1; ref_hold = 0;
          end
        end
      end else if (inject == 1 && in_burst && nref < 2 && $urandom_range(0, 5) == 0) begin
        ref_req = 1'b1; ref_hold = 1; hold_cnt = int'($urandom_range(1, 5)); nref++;
      end else if (inject == 2 && nref == 0 && bi == 0 && in_burst && acked) begin
        ref_req = 1'b1; ref_hold = 1; hold_cnt = 3; nref++;
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL frame_timeout: busy %b after budget, expected 0", busy); end
    checks++;
    if (bi !== TOTAL) begin errors++; $display("FAIL frame_bursts: got %0d, expected %0d", bi, TOTAL); end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL frame_done: got %b, expected 1", done); end
    ref_req = 1'b0; ar_done = 1'b0; ref_hold = 0;
    ever_done = 1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    rstn = 1'b1;
  endtask

  task automatic test_no_init();
    init_done = 1'b0;
    @(posedge clk); #1 wr_go = 1'b1;
    @(posedge clk); #1 wr_go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cmd !== 3'b000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL no_init: cmd %b busy %b, expected 000 and 0", cmd, busy);
      end
      @(posedge clk); #1;
    end
    init_done = 1'b1;
    start_frame();
    wait_frame(0, 0);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      gap_en = 1'($urandom_range(0, 1));
      start_frame();
      wait_frame(1, 0);
    end
    gap_en = 0;
  endtask

  task automatic test_refresh();
    start_frame();
    wait_frame(2, 0);
  endtask

  task automatic test_ack_gap();
    gap_en = 1;
    start_frame();
    wait_frame(0, 0);
    gap_en = 0;
  endtask

  task automatic test_back_to_back();
    start_frame();
    wait_frame(0, 1);
    start_frame();
    wait_frame(0, 0);
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    start_frame();
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (bi == 2 && in_burst && acked) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reset_mid_reach: line 1 data phase not reached, burst %0d", bi); end
    rstn = 1'b0;
    @(posedge clk);
    #1 check_reset_outputs("reset_mid");
    rstn = 1'b1;
    ever_done = 0;
    start_frame();
    wait_frame(0, 0);
  endtask

  initial begin
    rstn = 1'b0; init_done = 1'b0; wr_go = 1'b0; ref_req = 1'b0; ar_done = 1'b0; ack = 1'b0;
    gap_en = 0; ref_hold = 0; ever_done = 0; checks = 0; errors = 0; bi = 0;
    in_burst = 0; acked = 0; words = 0; bd_cnt = 0; lat = 1; lat_cnt = 0; gap_cnt = 0; tail_cnt = 0;
    fork
      monitor();
    join_none
    test_reset();
    test_no_init();
    test_random_frames();
    test_refresh();
    test_ack_gap();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
